perf_cntr_bank: RTL and testbench
=================================

// Module: perf_cntr_bank
// PURPOSE
//  Synthesizable, parametrised bank of hardware performance counters.
//  Replaces fixed testbench-only mcycle/minstret/branch counters with NUM_CNTRS generic channels.
//  Each channel counts one event strobe. Counters are readable and writable over a 32-bit
//  memory-mapped port, so firmware on the CPU inside main can sample them on the board.
//  Adds a global enable, a freeze input, atomic snapshot reads of wide counters,
//  wrap/saturate mode and sticky overflow flags.
// PARAMETERS
//  NUM_CNTRS   4   number of counter channels, 1..16
//  CNTR_WIDTH  64  bits per counter, 1..64
//  SATURATE    0   0: counter wraps to 0 on overflow; 1: counter holds at all-ones
//  ADDR_WIDTH  8   byte-address bits decoded; addr[1:0] ignored
// PORTS
//  clk_i         in   1             system clock
//  rst_i         in   1             synchronous active-high reset
//  freeze_i      in   1             1 = no counter advances (e.g. end of simulation)
//  evt_i         in   NUM_CNTRS     per-channel event strobe; +1 per cycle when high
//  bus_addr_i    in   ADDR_WIDTH    byte address
//  bus_wen_i     in   1             write strobe, single cycle
//  bus_wdata_i   in   32            write data
//  bus_ren_i     in   1             read strobe, single cycle
//  bus_rdata_o   out  32            read data, valid when bus_rvalid_o=1
//  bus_rvalid_o  out  1             read response strobe
//  ovf_o         out  NUM_CNTRS     sticky overflow flags (same as OVF register)
// BEHAVIOUR
//  Register map (word index w = bus_addr_i[ADDR_WIDTH-1:2]):
//   w=2i   CNTi_LO: bits [31:0] of counter i
//   w=2i+1 CNTi_HI: bits [CNTR_WIDTH-1:32] of counter i, zero-extended;
//          reads 0 and ignores writes when CNTR_WIDTH<=32
//   w=2N   CTRL: bit0 EN (R/W, reset 1); bit1 CLR (write-1 clears all counters and
//          OVF; self-clearing, reads 0)
//   w=2N+1 OVF: per-channel sticky flags, write-1-to-clear
//   other  reads 0, writes ignored
//  Reset: all counters 0, OVF 0, EN 1, snapshot 0, bus_rdata_o 0, bus_rvalid_o 0.
//  Count: counter i increments when evt_i[i] && EN && !freeze_i. Widths are exactly CNTR_WIDTH.
//  Overflow: an increment at all-ones sets OVF[i]. With SATURATE=0 the counter wraps to 0;
//   with SATURATE=1 it stays at all-ones.
//  Read latency: fixed 1 cycle. bus_ren_i in cycle T gives bus_rvalid_o=1 and
//   bus_rdata_o at T+1. bus_rvalid_o is high for exactly one cycle per read.
//   bus_rdata_o holds its last value otherwise. Back-to-back reads every cycle are supported.
//  Atomic snapshot: a read of CNTi_LO returns the counter value held at cycle T, before
//   any increment in T. The same read latches bits [CNTR_WIDTH-1:32] into a single
//   shared snapshot register. A following read of any CNTj_HI returns the snapshot,
//   not the live value. Firmware must read LO then HI of the same counter.
//  Writes: CNTi_LO/HI writes load the addressed bits; the other half is unchanged.
//  Priority in one cycle, highest first:
//   rst_i > CLR write > direct counter write > increment.
//   A written counter does not also increment in that cycle.
//  Simultaneous OVF W1C and a new overflow on the same channel leave the flag set.
//  Simultaneous bus_ren_i and bus_wen_i: the write takes effect, and the read returns the
//   pre-write value.
//  freeze_i and EN affect counting only; bus access keeps working.
//  Reset asserted mid-operation: a pending read response is dropped (bus_rvalid_o=0
//   in the next cycle).
// TESTING
//  1. Reset, then evt_i[0]=1 for 10 cycles with EN=1 -> CNT0_LO=10, CNT0_HI=0, OVF=0.
//  2. CNTR_WIDTH=8, SATURATE=0: load 0xFE, then 3 events -> CNT0_LO=0x01, OVF[0]=1.
//     Same with SATURATE=1 -> CNT0_LO=0xFF, OVF[0]=1.
//  3. CNTR_WIDTH=64: write CNT1_HI=0, CNT1_LO=0xFFFFFFFF, keep evt_i[1]=1, read LO then HI
//     -> LO=0xFFFFFFFF, HI=0 (snapshot, not the live value 1).
//  4. freeze_i=1 (or CTRL.EN=0) with all evt_i=1 for 20 cycles -> all counters unchanged;
//     reads still respond at T+1.
//  5. CTRL write 0x3 in the same cycle as evt_i=all ones -> all counters 0, OVF 0, EN=1.
//  6. Read issued, rst_i asserted the next cycle -> bus_rvalid_o=0, rdata 0, counters 0.

Source files
------------

// File: rtl/perf_cntr_bank.sv
// perf_cntr_bank: parametrised bank of event counters behind a 32-bit memory-mapped port.
//
// Each channel counts one event strobe and can be read or written by firmware. The bank has
// a global enable, a freeze input, wrap or saturate behaviour and sticky overflow flags.
// Wide counters are read atomically: a LO read also captures the upper bits for a later HI read.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   freeze_i      1 = no counter advances
//   evt_i         per-channel event strobe, +1 per cycle while high
//   bus_addr_i    byte address, bits [1:0] ignored
//   bus_wen_i     single-cycle write strobe
//   bus_wdata_i   write data
//   bus_ren_i     single-cycle read strobe
//   bus_rdata_o   read data, valid with bus_rvalid_o, held otherwise
//   bus_rvalid_o  read response strobe, one cycle after bus_ren_i
//   ovf_o         sticky per-channel overflow flags
//
// Word map (w = bus_addr_i[ADDR_WIDTH-1:2]):
//   2i CNTi_LO, 2i+1 CNTi_HI (snapshot on read), 2N CTRL {CLR, EN}, 2N+1 OVF (W1C).
module perf_cntr_bank #(
    parameter int unsigned NUM_CNTRS  = 4,
    parameter int unsigned CNTR_WIDTH = 64,
    parameter bit          SATURATE   = 1'b0,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  freeze_i,
    input  logic [NUM_CNTRS-1:0]  evt_i,
    input  logic [ADDR_WIDTH-1:0] bus_addr_i,
    input  logic                  bus_wen_i,
    input  logic [31:0]           bus_wdata_i,
    input  logic                  bus_ren_i,
    output logic [31:0]           bus_rdata_o,
    output logic                  bus_rvalid_o,
    output logic [NUM_CNTRS-1:0]  ovf_o
);

    localparam int unsigned CtrlWord = 2 * NUM_CNTRS;
    localparam int unsigned OvfWord  = 2 * NUM_CNTRS + 1;

    typedef logic [CNTR_WIDTH-1:0] cnt_t;

    cnt_t                 cnt_q [NUM_CNTRS];
    cnt_t                 cnt_d [NUM_CNTRS];
    logic [NUM_CNTRS-1:0] ovf_q, ovf_d;
    logic                 en_q, en_d;
    logic [31:0]          snap_q, snap_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;

    logic [31:0]          word_idx;
    logic [31:0]          rd_data;
    logic                 rd_snap_load;
    logic [31:0]          rd_snap_val;
    logic                 unused_addr_lsbs;

    // Widen a counter to 64 bits so LO/HI halves can be sliced for any CNTR_WIDTH.
    function automatic logic [63:0] zext(input cnt_t v);
        logic [63:0] r;
        r = '0;
        r[CNTR_WIDTH-1:0] = v;
        return r;
    endfunction

    assign word_idx         = 32'(bus_addr_i[ADDR_WIDTH-1:2]);
    assign unused_addr_lsbs = ^bus_addr_i[1:0];

    // Read mux, evaluated on pre-update state so a same-cycle write or increment is not seen.
    always_comb begin
        logic [63:0] tmp;
        rd_data      = '0;
        rd_snap_load = 1'b0;
        rd_snap_val  = '0;
        tmp          = '0;
        for (int i = 0; i < int'(NUM_CNTRS); i++) begin
            if (word_idx == 32'(2 * i)) begin
                tmp          = zext(cnt_q[i]);
                rd_data      = tmp[31:0];
                rd_snap_load = 1'b1;
                rd_snap_val  = tmp[63:32];
            end else if (word_idx == 32'(2 * i + 1)) begin
                rd_data = snap_q;
            end
        end
        if (word_idx == CtrlWord) begin
            rd_data = {31'b0, en_q};
        end else if (word_idx == OvfWord) begin
            rd_data = 32'(ovf_q);
        end
    end

    // Next-state: CLR write > direct counter write > increment.
    always_comb begin
        logic [63:0]          tmp;
        logic                 wr_lo;
        logic                 wr_hi;
        logic [NUM_CNTRS-1:0] ovf_set;
        logic                 inc_en;

        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        en_d     = en_q;
        snap_d   = snap_q;
        rdata_d  = rdata_q;
        rvalid_d = bus_ren_i;
        ovf_set  = '0;
        tmp      = '0;
        wr_lo    = 1'b0;
        wr_hi    = 1'b0;
        inc_en   = en_q & ~freeze_i;

        if (bus_ren_i) begin
            rdata_d = rd_data;
            if (rd_snap_load) begin
                snap_d = rd_snap_val;
            end
        end

        for (int i = 0; i < int'(NUM_CNTRS); i++) begin
            wr_lo = bus_wen_i && (word_idx == 32'(2 * i));
            wr_hi = bus_wen_i && (word_idx == 32'(2 * i + 1));
            tmp   = zext(cnt_q[i]);
            if (wr_lo) begin
                tmp[31:0] = bus_wdata_i;
            end else if (wr_hi) begin
                // Bits above CNTR_WIDTH are dropped by the truncation below.
                tmp[63:32] = bus_wdata_i;
            end
            if (wr_lo || wr_hi) begin
                cnt_d[i] = tmp[CNTR_WIDTH-1:0];
            end else if (evt_i[i] && inc_en) begin
                if (cnt_q[i] == '1) begin
                    ovf_set[i] = 1'b1;
                    cnt_d[i]   = SATURATE ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + cnt_t'(1);
                end
            end
        end

        // A fresh overflow wins over a same-cycle W1C on that channel.
        if (bus_wen_i && (word_idx == OvfWord)) begin
            ovf_d = ovf_q & ~bus_wdata_i[NUM_CNTRS-1:0];
        end
        ovf_d = ovf_d | ovf_set;

        if (bus_wen_i && (word_idx == CtrlWord)) begin
            en_d = bus_wdata_i[0];
            if (bus_wdata_i[1]) begin
                for (int i = 0; i < int'(NUM_CNTRS); i++) begin
                    cnt_d[i] = '0;
                end
                ovf_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_CNTRS); i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q    <= '0;
            en_q     <= 1'b1;
            snap_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CNTRS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q    <= ovf_d;
            en_q     <= en_d;
            snap_q   <= snap_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus_rdata_o  = rdata_q;
    assign bus_rvalid_o = rvalid_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_perf_cntr_bank.sv
// Directed bench for perf_cntr_bank: dut 0 is 64-bit wrap, dut 1 is 8-bit wrap,
// dut 2 is 8-bit saturate. All share clock and reset.
module tb_perf_cntr_bank;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic [3:0]  evt    [3];
    logic [7:0]  addr   [3];
    logic        wen    [3];
    logic [31:0] wdata  [3];
    logic        ren    [3];
    logic [31:0] rdata  [3];
    logic        rvalid [3];
    logic [3:0]  ovf    [3];

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] ACtrl = 8'd32;
    localparam logic [7:0] AOvf  = 8'd36;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        perf_cntr_bank #(
            .NUM_CNTRS (4),
            .CNTR_WIDTH((g == 0) ? 64 : 8),
            .SATURATE  (g == 2),
            .ADDR_WIDTH(8)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .freeze_i    (freeze),
            .evt_i       (evt[g]),
            .bus_addr_i  (addr[g]),
            .bus_wen_i   (wen[g]),
            .bus_wdata_i (wdata[g]),
            .bus_ren_i   (ren[g]),
            .bus_rdata_o (rdata[g]),
            .bus_rvalid_o(rvalid[g]),
            .ovf_o       (ovf[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic wr(input int d, input logic [7:0] a, input logic [31:0] v);
        addr[d]  = a;
        wdata[d] = v;
        wen[d]   = 1'b1;
        @(posedge clk);
        #1;
        wen[d] = 1'b0;
    endtask

    task automatic rd(input int d, input logic [7:0] a, output logic [31:0] v, output logic vld);
        addr[d] = a;
        ren[d]  = 1'b1;
        @(posedge clk);
        #1;
        ren[d] = 1'b0;
        v      = rdata[d];
        vld    = rvalid[d];
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        vld;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rvalid[d] !== 1'b0 || rdata[d] !== 32'h0 || ovf[d] !== 4'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got rvalid=%b rdata=%h ovf=%h want 0 0 0",
                         d, rvalid[d], rdata[d], ovf[d]);
            end
        end
        rd(0, ACtrl, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'h1) begin
            errors++;
            $display("FAIL reset_ctrl got vld=%b %h want 1 00000001", vld, v);
        end
        rd(0, AOvf, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'h0) begin
            errors++;
            $display("FAIL reset_ovf got vld=%b %h want 1 00000000", vld, v);
        end
        wr(0, 8'hF0, 32'hDEADBEEF);
        rd(0, 8'hF0, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'h0) begin
            errors++;
            $display("FAIL unmapped got vld=%b %h want 1 00000000", vld, v);
        end
    endtask

    task automatic test_count();
        logic [31:0] v;
        logic        vld;
        evt[0] = 4'b0001;
        repeat (10) @(posedge clk);
        #1;
        evt[0] = 4'b0000;
        rd(0, 8'd0, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'd10) begin
            errors++;
            $display("FAIL count_lo got vld=%b %h want 1 0000000a", vld, v);
        end
        rd(0, 8'd4, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'd0) begin
            errors++;
            $display("FAIL count_hi got vld=%b %h want 1 00000000", vld, v);
        end
        checks++;
        if (ovf[0] !== 4'h0) begin
            errors++;
            $display("FAIL count_ovf got %h want 0", ovf[0]);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        logic        vld;
        logic [31:0] exp_lo;
        for (int d = 1; d < 3; d++) begin
            exp_lo = (d == 1) ? 32'h01 : 32'hFF;
            wr(d, 8'd0, 32'hFE);
            evt[d] = 4'b0001;
            repeat (3) @(posedge clk);
            #1;
            evt[d] = 4'b0000;
            rd(d, 8'd0, v, vld);
            checks++;
            if (vld !== 1'b1 || v !== exp_lo) begin
                errors++;
                $display("FAIL ovf_lo dut%0d got vld=%b %h want 1 %h", d, vld, v, exp_lo);
            end
            checks++;
            if (ovf[d] !== 4'b0001) begin
                errors++;
                $display("FAIL ovf_flag dut%0d got %b want 0001", d, ovf[d]);
            end
            rd(d, AOvf, v, vld);
            checks++;
            if (vld !== 1'b1 || v !== 32'h1) begin
                errors++;
                $display("FAIL ovf_reg dut%0d got vld=%b %h want 1 00000001", d, vld, v);
            end
            wr(d, 8'd4, 32'hFFFFFFFF);
            rd(d, 8'd0, v, vld);
            rd(d, 8'd4, v, vld);
            checks++;
            if (vld !== 1'b1 || v !== 32'h0) begin
                errors++;
                $display("FAIL narrow_hi dut%0d got vld=%b %h want 1 00000000", d, vld, v);
            end
        end
        wr(1, AOvf, 32'h1);
        checks++;
        if (ovf[1] !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_w1c got %b want 0000", ovf[1]);
        end
        // Saturated counter keeps overflowing while the flag is being cleared.
        evt[2] = 4'b0001;
        wr(2, AOvf, 32'h1);
        evt[2] = 4'b0000;
        checks++;
        if (ovf[2] !== 4'b0001) begin
            errors++;
            $display("FAIL ovf_w1c_vs_set got %b want 0001", ovf[2]);
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] v;
        logic        vld;
        wr(0, 8'd12, 32'h0);
        wr(0, 8'd8, 32'hFFFFFFFF);
        evt[0] = 4'b0010;
        rd(0, 8'd8, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL snap_lo got vld=%b %h want 1 ffffffff", vld, v);
        end
        rd(0, 8'd12, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'h0) begin
            errors++;
            $display("FAIL snap_hi got vld=%b %h want 1 00000000", vld, v);
        end
        evt[0] = 4'b0000;
        rd(0, 8'd8, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'h1) begin
            errors++;
            $display("FAIL live_lo got vld=%b %h want 1 00000001", vld, v);
        end
        rd(0, 8'd12, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'h1) begin
            errors++;
            $display("FAIL live_hi got vld=%b %h want 1 00000001", vld, v);
        end
    endtask

    task automatic test_freeze();
        logic [31:0] v;
        logic        vld;
        logic [31:0] exp_lo [4];
        exp_lo = '{32'd10, 32'd1, 32'd0, 32'd0};
        freeze = 1'b1;
        evt[0] = 4'hF;
        repeat (10) @(posedge clk);
        #1;
        rd(0, 8'd0, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'd10) begin
            errors++;
            $display("FAIL freeze_read got vld=%b %h want 1 0000000a", vld, v);
        end
        repeat (9) @(posedge clk);
        #1;
        evt[0] = 4'h0;
        freeze = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(0, 8'(8 * i), v, vld);
            checks++;
            if (vld !== 1'b1 || v !== exp_lo[i]) begin
                errors++;
                $display("FAIL freeze_cnt%0d got vld=%b %h want 1 %h", i, vld, v, exp_lo[i]);
            end
        end
        wr(0, ACtrl, 32'h0);
        evt[0] = 4'hF;
        repeat (20) @(posedge clk);
        #1;
        rd(0, ACtrl, v, vld);
        evt[0] = 4'h0;
        checks++;
        if (vld !== 1'b1 || v !== 32'h0) begin
            errors++;
            $display("FAIL en_off_ctrl got vld=%b %h want 1 00000000", vld, v);
        end
        for (int i = 0; i < 4; i++) begin
            rd(0, 8'(8 * i), v, vld);
            checks++;
            if (vld !== 1'b1 || v !== exp_lo[i]) begin
                errors++;
                $display("FAIL en_off_cnt%0d got vld=%b %h want 1 %h", i, vld, v, exp_lo[i]);
            end
        end
        wr(0, ACtrl, 32'h1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic        vld;
        addr[0] = 8'd0;
        ren[0]  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'd10) begin
            errors++;
            $display("FAIL b2b_first got vld=%b %h want 1 0000000a", rvalid[0], rdata[0]);
        end
        addr[0] = AOvf;
        @(posedge clk);
        #1;
        ren[0] = 1'b0;
        checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL b2b_second got vld=%b %h want 1 00000000", rvalid[0], rdata[0]);
        end
        addr[0] = 8'd0;
        @(posedge clk);
        #1;
        checks++;
        if (rvalid[0] !== 1'b0 || rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL b2b_idle got vld=%b %h want 0 00000000", rvalid[0], rdata[0]);
        end
        // Read and write together: the read sees the old value.
        addr[0]  = 8'd16;
        wdata[0] = 32'h55;
        ren[0]   = 1'b1;
        wen[0]   = 1'b1;
        @(posedge clk);
        #1;
        ren[0] = 1'b0;
        wen[0] = 1'b0;
        checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL rw_same got vld=%b %h want 1 00000000", rvalid[0], rdata[0]);
        end
        rd(0, 8'd16, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'h55) begin
            errors++;
            $display("FAIL rw_after got vld=%b %h want 1 00000055", vld, v);
        end
        evt[0] = 4'b1000;
        wr(0, 8'd24, 32'd5);
        evt[0] = 4'b0000;
        rd(0, 8'd24, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'd5) begin
            errors++;
            $display("FAIL wr_beats_inc got vld=%b %h want 1 00000005", vld, v);
        end
    endtask

    task automatic test_clear();
        logic [31:0] v;
        logic        vld;
        for (int d = 0; d < 3; d += 2) begin
            wr(d, ACtrl, 32'h0);
            evt[d] = 4'hF;
            wr(d, ACtrl, 32'h3);
            evt[d] = 4'h0;
            checks++;
            if (ovf[d] !== 4'h0) begin
                errors++;
                $display("FAIL clr_ovf dut%0d got %b want 0000", d, ovf[d]);
            end
            for (int i = 0; i < 4; i++) begin
                rd(d, 8'(8 * i), v, vld);
                checks++;
                if (vld !== 1'b1 || v !== 32'h0) begin
                    errors++;
                    $display("FAIL clr_cnt%0d dut%0d got vld=%b %h want 1 00000000",
                             i, d, vld, v);
                end
            end
            rd(d, ACtrl, v, vld);
            checks++;
            if (vld !== 1'b1 || v !== 32'h1) begin
                errors++;
                $display("FAIL clr_en dut%0d got vld=%b %h want 1 00000001", d, vld, v);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] v;
        logic        vld;
        wr(0, 8'd0, 32'd7);
        addr[0] = 8'd0;
        ren[0]  = 1'b1;
        @(posedge clk);
        #1;
        ren[0] = 1'b0;
        rst    = 1'b1;
        checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'd7) begin
            errors++;
            $display("FAIL pre_rst_read got vld=%b %h want 1 00000007", rvalid[0], rdata[0]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rvalid[0] !== 1'b0 || rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL rst_drop got vld=%b %h want 0 00000000", rvalid[0], rdata[0]);
        end
        rst = 1'b0;
        rd(0, 8'd0, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'h0) begin
            errors++;
            $display("FAIL rst_cnt got vld=%b %h want 1 00000000", vld, v);
        end
        rd(1, 8'd0, v, vld);
        checks++;
        if (vld !== 1'b1 || v !== 32'h0) begin
            errors++;
            $display("FAIL rst_cnt_dut1 got vld=%b %h want 1 00000000", vld, v);
        end
    endtask

    initial begin
        rst    = 1'b1;
        freeze = 1'b0;
        for (int d = 0; d < 3; d++) begin
            evt[d]   = '0;
            addr[d]  = '0;
            wen[d]   = 1'b0;
            wdata[d] = '0;
            ren[d]   = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_count();
        test_overflow();
        test_snapshot();
        test_freeze();
        test_back_to_back();
        test_clear();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
